// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC sequencing and memory request/ack handshake
// Macro FETCH_MISALIGN_EN adds misaligned-branch detection (FAULT state, MISALIGN output).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        INSTR_REQ,
  input  logic        BRANCH,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
`ifdef FETCH_MISALIGN_EN
  output logic        MISALIGN,
`endif
  output logic [31:0] PC
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] STEP = 32'(PC_STEP);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [2:0] {S_REQ = 3'b001, S_HOLD = 3'b010, S_FAULT = 3'b100} state_t;
`else
  typedef enum logic [1:0] {S_REQ = 2'b01, S_HOLD = 2'b10} state_t;
`endif

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        mem_req_q;
  logic        valid_q;
  logic [31:0] branch_pc;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;
  logic misalign_br;
  assign misalign_br = BRANCH && (BRANCH_TARGET[1:0] != 2'b00);
  assign branch_pc   = BRANCH_TARGET;
  assign MISALIGN    = misalign_q;
`else
  logic unused_tgt_bits;
  assign unused_tgt_bits = &{1'b0, BRANCH_TARGET[1:0]};
  assign branch_pc       = {BRANCH_TARGET[31:2], 2'b00};
`endif

  // An ACK only counts against a request actually on the bus, so the idle
  // cycle right after reset release cannot complete a fetch.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_REQ: begin
          mem_req_q <= 1'b1;
          if (mem_req_q && MEM_ACK) begin
            instr_q   <= MEM_RDATA;
            valid_q   <= 1'b1;
            mem_req_q <= 1'b0;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (INSTR_REQ) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            if (misalign_br) begin
              pc_q       <= branch_pc;
              misalign_q <= 1'b1;
              state      <= S_FAULT;
            end else begin
              pc_q      <= BRANCH ? branch_pc : pc_q + STEP;
              mem_req_q <= 1'b1;
              state     <= S_REQ;
            end
`else
            pc_q      <= BRANCH ? branch_pc : pc_q + STEP;
            mem_req_q <= 1'b1;
            state     <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_EN
        S_FAULT: begin
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
`endif
        default: state <= S_REQ;
      endcase
    end
  end

  assign MEM_REQ     = mem_req_q;
  assign MEM_ADDR    = pc_q;
  assign PC          = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
// Build with FETCH_MISALIGN_EN defined to cover the FAULT path.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RES, INSTR_REQ, BRANCH, MEM_ACK;
  logic [31:0] BRANCH_TARGET, MEM_RDATA;
  logic        MEM_REQ, INSTR_VALID;
  logic [31:0] MEM_ADDR, INSTR, PC;
`ifdef FETCH_MISALIGN_EN
  logic        MISALIGN;
`endif

  fetch_unit dut (
    .CLK(CLK), .RES(RES), .INSTR_REQ(INSTR_REQ), .BRANCH(BRANCH),
    .BRANCH_TARGET(BRANCH_TARGET), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
`ifdef FETCH_MISALIGN_EN
    .MISALIGN(MISALIGN),
`endif
    .PC(PC)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising INSTR_VALID must match the oldest expected fetch.
  logic prev_valid = 1'b0;
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (INSTR_VALID === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("instr", INSTR, e.data);
        check("instr_pc", PC, e.addr);
        check("valid_latency", cyc, e.edge_n);
      end
    end
    prev_valid = (INSTR_VALID === 1'b1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int delay, input bit with_req);
    int   t;
    exp_t e;
    t = 0;
    while (MEM_REQ !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    if (MEM_REQ !== 1'b1) begin
      check("mem_req_timeout", 32'd0, 32'd1);
      return;
    end
    check("mem_addr", MEM_ADDR, addr);
    check("valid_in_req", INSTR_VALID, 32'd0);
    repeat (delay) step();
    check("addr_stable", MEM_ADDR, addr);
    MEM_ACK       = 1'b1;
    MEM_RDATA     = data;
    INSTR_REQ     = with_req;
    BRANCH        = with_req;
    BRANCH_TARGET = 32'h0000_0200;
    e.addr   = addr;
    e.data   = data;
    e.edge_n = cyc + 1;
    sb.push_back(e);
    step();
    MEM_ACK   = 1'b0;
    INSTR_REQ = 1'b0;
    BRANCH    = 1'b0;
    check("hold_mem_req", MEM_REQ, 32'd0);
    check("hold_valid", INSTR_VALID, 32'd1);
    check("hold_pc", PC, addr);
  endtask

  task automatic ireq(input bit br, input logic [31:0] tgt);
    INSTR_REQ     = 1'b1;
    BRANCH        = br;
    BRANCH_TARGET = tgt;
    step();
    INSTR_REQ = 1'b0;
    BRANCH    = 1'b0;
    check("req_after_ireq", MEM_REQ, 32'd1);
    check("valid_after_ireq", INSTR_VALID, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b1; INSTR_REQ = 1'b0; BRANCH = 1'b0; MEM_ACK = 1'b0;
    BRANCH_TARGET = 32'h0; MEM_RDATA = 32'h0;
    repeat (3) step();
    check("rst_mem_req", MEM_REQ, 32'd0);
    check("rst_instr", INSTR, 32'h0000_0013);
    check("rst_valid", INSTR_VALID, 32'd0);
    check("rst_pc", PC, 32'h0);
    RES = 1'b0;
    step();
    check("first_req", MEM_REQ, 32'd1);

    fetch(32'h0, 32'h0000_0093, 3, 1'b0);
    ireq(1'b0, 32'h0);
    fetch(32'h4, 32'h0010_0113, 0, 1'b0);
    ireq(1'b0, 32'h0);
    fetch(32'h8, 32'h0020_0193, 1, 1'b0);
    ireq(1'b0, 32'h0);
    // ACK and INSTR_REQ together: the request must be dropped
    fetch(32'hC, 32'h0030_0213, 0, 1'b1);
    check("dropped_ireq_no_req", MEM_REQ, 32'd0);
    ireq(1'b1, 32'h0000_0100);
    fetch(32'h100, 32'h0040_0293, 2, 1'b0);
    ireq(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0050_0313, 0, 1'b0);
    ireq(1'b0, 32'h0);
    INSTR_REQ = 1'b1; BRANCH = 1'b1; BRANCH_TARGET = 32'h0000_0200;
    step();
    INSTR_REQ = 1'b0; BRANCH = 1'b0;
    check("ireq_in_req_pc", PC, 32'h0);
    fetch(32'h0, 32'h0060_0393, 1, 1'b0);

`ifdef FETCH_MISALIGN_EN
    INSTR_REQ = 1'b1; BRANCH = 1'b1; BRANCH_TARGET = 32'h0000_0102;
    step();
    INSTR_REQ = 1'b0; BRANCH = 1'b0;
    check("fault_misalign", MISALIGN, 32'd1);
    check("fault_mem_req", MEM_REQ, 32'd0);
    check("fault_valid", INSTR_VALID, 32'd0);
    check("fault_pc", PC, 32'h0000_0102);
    MEM_ACK = 1'b1; INSTR_REQ = 1'b1; MEM_RDATA = 32'hBAD0_BAD0;
    repeat (3) step();
    MEM_ACK = 1'b0; INSTR_REQ = 1'b0;
    check("fault_sticky", MISALIGN, 32'd1);
    check("fault_mem_req_held", MEM_REQ, 32'd0);
    check("fault_pc_held", PC, 32'h0000_0102);
    RES = 1'b1;
    step();
    RES = 1'b0;
    check("fault_cleared", MISALIGN, 32'd0);
    fetch(32'h0, 32'h0070_0413, 0, 1'b0);
`else
    ireq(1'b1, 32'h0000_0102);
    fetch(32'h100, 32'h0070_0413, 0, 1'b0);
`endif

    // Reset with a concurrent ACK: the ACK must be discarded
    ireq(1'b0, 32'h0);
    RES = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    step();
    RES = 1'b0; MEM_ACK = 1'b0;
    check("rst_ack_instr", INSTR, 32'h0000_0013);
    check("rst_ack_valid", INSTR_VALID, 32'd0);
    check("rst_ack_pc", PC, 32'h0);
    check("rst_ack_req", MEM_REQ, 32'd0);
    step();
    check("rst_ack_req_up", MEM_REQ, 32'd1);
    check("rst_ack_addr", MEM_ADDR, 32'h0);
    fetch(32'h0, 32'h0080_0493, 2, 1'b0);

    repeat (3) step();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
